// File: rtl/keypad_emulator.sv
// keypad_emulator: responder end of a 4x4 row-drive/column-sense keypad.
// Presses one latched key with programmable contact bounce and hold time.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 1200,
    parameter int BOUNCE_TOGGLE = 100,
    parameter int HOLD_W        = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        keypad_rows,
    output logic [3:0]        keypad_cols,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              press_req,
    output logic              busy,
    output logic              done
);

    localparam int M1 = (BOUNCE_CYCLES > BOUNCE_TOGGLE) ?
                        BOUNCE_CYCLES : BOUNCE_TOGGLE;
    localparam int M2 = (M1 > (2 ** HOLD_W)) ? M1 : (2 ** HOLD_W);
    localparam int CW = $clog2(M2) + 1;

    localparam logic [CW-1:0] BC_LAST =
        CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TG_LAST =
        CW'((BOUNCE_TOGGLE > 1) ? BOUNCE_TOGGLE - 1 : 0);
    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_PRESS,
        HOLD,
        BOUNCE_RELEASE,
        DONE
    } state_t;

    state_t        state, state_d;
    logic          contact, contact_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] tog, tog_d;
    logic [CW-1:0] hold_last, hold_last_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    rc_map;

    // Key code to {row, col} position on the matrix
    always_comb begin
        rc_map = 4'b0000;
        unique case (key_code)
            4'h1: rc_map = {2'd0, 2'd0};
            4'h2: rc_map = {2'd0, 2'd1};
            4'h3: rc_map = {2'd0, 2'd2};
            4'hA: rc_map = {2'd0, 2'd3};
            4'h4: rc_map = {2'd1, 2'd0};
            4'h5: rc_map = {2'd1, 2'd1};
            4'h6: rc_map = {2'd1, 2'd2};
            4'hB: rc_map = {2'd1, 2'd3};
            4'h7: rc_map = {2'd2, 2'd0};
            4'h8: rc_map = {2'd2, 2'd1};
            4'h9: rc_map = {2'd2, 2'd2};
            4'hC: rc_map = {2'd2, 2'd3};
            4'hE: rc_map = {2'd3, 2'd0};
            4'h0: rc_map = {2'd3, 2'd1};
            4'hF: rc_map = {2'd3, 2'd2};
            4'hD: rc_map = {2'd3, 2'd3};
        endcase
    end

    // State, contact, counters and latched key/hold registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            contact   <= 1'b0;
            cnt       <= '0;
            tog       <= '0;
            hold_last <= '0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
        end else begin
            state     <= state_d;
            contact   <= contact_d;
            cnt       <= cnt_d;
            tog       <= tog_d;
            hold_last <= hold_last_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    // Sequence control: bounce toggling, hold timing, phase changes
    always_comb begin
        state_d     = state;
        contact_d   = contact;
        cnt_d       = cnt;
        tog_d       = tog;
        hold_last_d = hold_last;
        row_d       = row_q;
        col_d       = col_q;
        unique case (state)
            IDLE: begin
                contact_d = 1'b0;
                if (press_req) begin
                    row_d       = rc_map[3:2];
                    col_d       = rc_map[1:0];
                    hold_last_d = (hold_cycles == '0) ? '0 :
                                  CW'(hold_cycles - HOLD_W'(1));
                    cnt_d       = '0;
                    tog_d       = '0;
                    contact_d   = 1'b1;
                    state_d     = HAS_BOUNCE ? BOUNCE_PRESS : HOLD;
                end
            end
            BOUNCE_PRESS: begin
                if (cnt == BC_LAST) begin
                    contact_d = 1'b1;
                    cnt_d     = '0;
                    tog_d     = '0;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (tog == TG_LAST) begin
                        tog_d     = '0;
                        contact_d = ~contact;
                    end else begin
                        tog_d = tog + CW'(1);
                    end
                end
            end
            HOLD: begin
                contact_d = 1'b1;
                if (cnt == hold_last) begin
                    contact_d = 1'b0;
                    cnt_d     = '0;
                    tog_d     = '0;
                    state_d   = HAS_BOUNCE ? BOUNCE_RELEASE : DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            BOUNCE_RELEASE: begin
                if (cnt == BC_LAST) begin
                    contact_d = 1'b0;
                    cnt_d     = '0;
                    tog_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (tog == TG_LAST) begin
                        tog_d     = '0;
                        contact_d = ~contact;
                    end else begin
                        tog_d = tog + CW'(1);
                    end
                end
            end
            DONE: begin
                contact_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                contact_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Column sense follows the row drive with no register in the path
    always_comb begin
        keypad_cols = 4'hF;
        if (contact && !keypad_rows[row_q])
            keypad_cols[col_q] = 1'b0;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: three emulator configurations driven in parallel
// and compared against a time-based model of the press sequence.
module tb_keypad_emulator;

    localparam int N  = 3;
    localparam int HW = 8;

    logic          clk;
    logic          reset;
    logic [3:0]    keypad_rows;
    logic [3:0]    key_code;
    logic [HW-1:0] hold_cycles;
    logic          press_req;
    logic [3:0]    cols [N];
    logic [N-1:0]  busy;
    logic [N-1:0]  done;

    int nchk = 0;
    int nerr = 0;

    keypad_emulator #(
        .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .HOLD_W(HW)
    ) u0 (
        .clk(clk), .reset(reset), .keypad_rows(keypad_rows),
        .keypad_cols(cols[0]), .key_code(key_code),
        .hold_cycles(hold_cycles), .press_req(press_req),
        .busy(busy[0]), .done(done[0])
    );

    keypad_emulator #(
        .BOUNCE_CYCLES(8), .BOUNCE_TOGGLE(2), .HOLD_W(HW)
    ) u1 (
        .clk(clk), .reset(reset), .keypad_rows(keypad_rows),
        .keypad_cols(cols[1]), .key_code(key_code),
        .hold_cycles(hold_cycles), .press_req(press_req),
        .busy(busy[1]), .done(done[1])
    );

    keypad_emulator #(
        .BOUNCE_CYCLES(7), .BOUNCE_TOGGLE(3), .HOLD_W(HW)
    ) u2 (
        .clk(clk), .reset(reset), .keypad_rows(keypad_rows),
        .keypad_cols(cols[2]), .key_code(key_code),
        .hold_cycles(hold_cycles), .press_req(press_req),
        .busy(busy[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: sequence position t since acceptance
    bit act [N];
    int t   [N];
    int mrow[N];
    int mcol[N];
    int mh  [N];

    int on0, busy0, done0;

    string KEYS = "123A456B789CE0FD";

    function automatic int bc_of(int i);
        return (i == 0) ? 0 : (i == 1) ? 8 : 7;
    endfunction

    function automatic int bt_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 3;
    endfunction

    task automatic locate(input logic [3:0] code,
                          output int r, output int c);
        r = 0;
        c = 0;
        for (int p = 0; p < 16; p++) begin
            byte ch;
            int  v;
            ch = KEYS[p];
            v  = (ch >= 8'h41) ? (ch - 8'h41 + 10) : (ch - 8'h30);
            if (v == int'(code)) begin
                r = p / 4;
                c = p % 4;
            end
        end
    endtask

    function automatic bit exp_contact(int i, int tt);
        int b = bc_of(i);
        int g = bt_of(i);
        int h = mh[i];
        if (tt < b)         return ((tt / g) % 2) == 0;
        if (tt < b + h)     return 1'b1;
        if (tt < 2 * b + h) return (((tt - b - h) / g) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        on0   = 0;
        busy0 = 0;
        done0 = 0;
    endtask

    // one clock: check outputs for current inputs, then advance model
    task automatic cyc(input logic [3:0] rows,
                       input logic req,
                       input logic rst);
        keypad_rows = rows;
        press_req   = req;
        reset       = rst;
        #1;
        for (int i = 0; i < N; i++) begin
            logic [3:0] ec;
            bit         eb;
            bit         ed;
            ec = 4'hF;
            eb = act[i];
            ed = act[i] && (t[i] == 2 * bc_of(i) + mh[i]);
            if (act[i] && exp_contact(i, t[i]) && !rows[mrow[i]])
                ec[mcol[i]] = 1'b0;
            check($sformatf("cols%0d", i), 32'(cols[i]), 32'(ec));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(eb));
            check($sformatf("done%0d", i), 32'(done[i]), 32'(ed));
        end
        if (cols[0] != 4'hF) on0++;
        if (busy[0]) busy0++;
        if (done[0]) done0++;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                if (t[i] == 2 * bc_of(i) + mh[i]) act[i] = 1'b0;
                else t[i]++;
            end else if (req) begin
                act[i] = 1'b1;
                t[i]   = 0;
                locate(key_code, mrow[i], mcol[i]);
                mh[i]  = (hold_cycles == '0) ? 1 : int'(hold_cycles);
            end
        end
        #1;
    endtask

    task automatic run(input logic [3:0] rows, input int n);
        for (int k = 0; k < n; k++) cyc(rows, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            act[i]  = 1'b0;
            t[i]    = 0;
            mrow[i] = 0;
            mcol[i] = 0;
            mh[i]   = 1;
        end
        clr_counts();
        reset       = 1'b1;
        press_req   = 1'b0;
        keypad_rows = 4'hF;
        key_code    = 4'h0;
        hold_cycles = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state with every row driven
        reset = 1'b0;
        run(4'h0, 3);

        // key 5, hold 10, row 1 held low
        key_code    = 4'h5;
        hold_cycles = 8'd10;
        clr_counts();
        cyc(4'b1101, 1'b1, 1'b0);
        run(4'b1101, 30);
        check("t1_closed_cycles", 32'(on0), 32'd10);
        check("t1_busy_cycles", 32'(busy0), 32'd11);
        check("t1_done_pulses", 32'(done0), 32'd1);

        // same press with a walking row scan
        clr_counts();
        cyc(4'b1110, 1'b1, 1'b0);
        for (int k = 1; k < 31; k++)
            cyc(~(4'b0001 << (k % 4)), 1'b0, 1'b0);
        check("t2_done_pulses", 32'(done0), 32'd1);

        // key D, row 3 low, bounce pattern on the bounced units
        key_code    = 4'hD;
        hold_cycles = 8'd4;
        cyc(4'b0111, 1'b1, 1'b0);
        run(4'b0111, 26);

        // second request during HOLD is ignored
        key_code    = 4'h7;
        hold_cycles = 8'd6;
        clr_counts();
        cyc(4'h0, 1'b1, 1'b0);
        run(4'h0, 2);
        key_code    = 4'h1;
        hold_cycles = 8'd2;
        cyc(4'h0, 1'b1, 1'b0);
        run(4'h0, 26);
        check("t4_done_pulses", 32'(done0), 32'd1);
        check("t4_closed_cycles", 32'(on0), 32'd6);

        // reset in the middle of HOLD, then a fresh press
        key_code    = 4'h9;
        hold_cycles = 8'd20;
        clr_counts();
        cyc(4'b1011, 1'b1, 1'b0);
        run(4'b1011, 5);
        cyc(4'b1011, 1'b0, 1'b1);
        run(4'b1011, 2);
        check("t5_no_done", 32'(done0), 32'd0);
        hold_cycles = 8'd3;
        cyc(4'b1011, 1'b1, 1'b0);
        run(4'b1011, 24);

        // hold 0 acts as 1; every code against the key map
        hold_cycles = 8'd0;
        for (int c = 0; c < 16; c++) begin
            int r;
            int cc;
            key_code = 4'(c);
            locate(key_code, r, cc);
            clr_counts();
            cyc(~(4'b0001 << r), 1'b1, 1'b0);
            run(~(4'b0001 << r), 20);
            check($sformatf("t6_closed_%0h", c), 32'(on0), 32'd1);
        end

        // random traffic with occasional reset
        for (int k = 0; k < 500; k++) begin
            key_code    = 4'($urandom);
            hold_cycles = HW'($urandom_range(0, 5));
            cyc(4'($urandom), ($urandom % 4) == 0,
                ($urandom % 70) == 0);
        end
        run(4'h0, 30);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 matrix keypad: the responder end of the row-drive/column-sense scan interface.
- Watches the scanner's active-low row drive and returns active-low column levels for one "pressed" key.
- Contact bounce and hold time are programmable.
- Used in hardware-in-loop benches and on a second board to exercise keypad_scanner, keypad_controller and the display path without a physical keypad.

Parameters:
- BOUNCE_CYCLES, 1200: length of each bounce phase (press and release) in clk cycles; 0 disables bounce.
- BOUNCE_TOGGLE, 100: contact toggle period during bounce, in clk cycles; must be >= 1.
- HOLD_W, 24: width of hold_cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- keypad_rows  input  4  row drive from scanner, active-low; bit r low = row r selected
- keypad_cols  output  4  column sense to scanner, active-low; 4'hF = no contact
- key_code  input  4  hex key to press; sampled only when a request is accepted
- hold_cycles  input  HOLD_W  stable-closed duration; sampled with key_code; 0 treated as 1
- press_req  input  1  start a press/release sequence; level-sampled in IDLE only
- busy  output  1  high from the cycle after acceptance until DONE completes
- done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Key map, code -> (row, col):
  - 1(0,0) 2(0,1) 3(0,2) A(0,3)
  - 4(1,0) 5(1,1) 6(1,2) B(1,3)
  - 7(2,0) 8(2,1) 9(2,2) C(2,3)
  - E(3,0) 0(3,1) F(3,2) D(3,3)
  - Row and col indices are latched at acceptance.
- Column output is combinational from the registered contact bit and the latched row/col. Zero latency from keypad_rows:
  - keypad_cols[c] = 0 iff contact=1, c == latched col, and keypad_rows[latched row] == 0.
  - All other bits are 1.
  - Several rows low at once: the rule above still holds, checking only the latched row.
- FSM states: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, DONE.
- IDLE:
  - contact=0, busy=0.
  - press_req=1 at edge N: latch key and hold, and zero the counter.
  - If BOUNCE_CYCLES>0: go to BOUNCE_PRESS with contact=1 at N+1. Otherwise go to HOLD with contact=1 at N+1.
- BOUNCE_PRESS:
  - Counter counts 0..BOUNCE_CYCLES-1.
  - contact inverts each time counter+1 is a multiple of BOUNCE_TOGGLE.
  - At the last count: contact=1, counter clears, go to HOLD.
- HOLD:
  - contact=1 for max(hold_cycles,1) cycles, then contact=0.
  - Go to BOUNCE_RELEASE, or to DONE if BOUNCE_CYCLES=0.
- BOUNCE_RELEASE:
  - Starts with contact=0 and toggles as in BOUNCE_PRESS.
  - At the last count: contact forced 0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- press_req while busy (including in DONE) is ignored; no queuing.
- Changes to key_code/hold_cycles after acceptance have no effect.
- Reset values: state IDLE, contact 0, keypad_cols 4'hF, busy 0, done 0, counters 0.
- Reset mid-sequence aborts with no done pulse; cols read 4'hF from the cycle after the reset edge.
- Counters are sized $clog2 of max(BOUNCE_CYCLES, BOUNCE_TOGGLE, 2^HOLD_W) + 1 bits and never wrap inside a phase.
- With BOUNCE_CYCLES=0, busy is high for hold+1 cycles (HOLD plus DONE).

Test Plan:
- BOUNCE_CYCLES=0, key 5, hold 10, keypad_rows=4'b1101 held -> keypad_cols=4'b1101 for exactly 10 cycles starting the cycle after press_req; done pulses once; busy high 11 cycles.
- Same press, keypad_rows cycling 1110/1101/1011/0111 each cycle -> cols=4'b1101 only on cycles where rows=1101, else 4'hF.
- BOUNCE_CYCLES=8, BOUNCE_TOGGLE=2, key D, rows=4'b0111 -> contact pattern 1,1,0,0,1,1,0,0, then 1 for hold, then 0,0,1,1,0,0,1,1 gated off to 0 at end; cols bit3 mirrors the pattern inverted.
- press_req pulsed again during HOLD with a different key -> ignored; only the original key's column asserts; single done.
- Reset asserted in the middle of HOLD -> next cycle cols=4'hF, busy=0, no done; a new press_req after reset works normally.
- hold_cycles=0, key 1 -> contact closed exactly 1 cycle; all 16 codes verified against the key map with the matching row driven low.
